// File: rtl/io_trig_filter_pkg.sv
// Shared types and default widths for the trigger input filter and its register block.
package trig_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } trig_fsm_t;

   localparam int FILT_W_DEF = 16;
   localparam int HOLD_W_DEF = 24;
   localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/io_trig_chan.sv
// One trigger channel: 2-flop sync, stability filter, rising-edge detect,
// holdoff FSM and accepted/dropped counters.
module io_trig_chan
   import trig_pkg::*;
#(
   parameter int FILT_W = FILT_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FILT_W-1:0] filter_len,
   input  logic [HOLD_W-1:0] holdoff,
   input  logic              trig_en,
   input  logic              cnt_clr,
   input  logic              din,
   output logic              filt_level,
   output logic              trig_pulse,
   output logic [CNT_W-1:0]  trig_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   logic [1:0]        sync;
   logic [FILT_W-1:0] stab_cnt;
   logic              filt_level_d;
   logic              rise;
   logic              accept;
   logic              drop;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   trig_fsm_t         state;
   trig_fsm_t         state_nxt;

   // sync[1] is the synchronised sample; filt_level only flips after a full
   // run of disagreeing samples, any agreement restarts the window.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync         <= '0;
         stab_cnt     <= '0;
         filt_level   <= 1'b0;
         filt_level_d <= 1'b0;
      end else begin
         sync         <= {sync[0], din};
         filt_level_d <= filt_level;
         if (sync[1] == filt_level) begin
            stab_cnt <= '0;
         end else if (stab_cnt == filter_len) begin
            filt_level <= sync[1];
            stab_cnt   <= '0;
         end else begin
            stab_cnt <= stab_cnt + FILT_W'(1);
         end
      end
   end

   assign rise = filt_level & ~filt_level_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      accept    = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (rise && trig_en) begin
               accept = 1'b1;
               if (holdoff != '0) begin
                  hold_nxt  = holdoff;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            // countdown runs regardless of the enable; the exit cycle still drops
            hold_nxt = hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) state_nxt = IDLE;
            if (rise && trig_en) drop = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         trig_pulse <= 1'b0;
         trig_cnt   <= '0;
         drop_cnt   <= '0;
      end else begin
         trig_pulse <= accept;
         trig_cnt   <= cnt_clr ? '0 : trig_cnt + CNT_W'(accept);
         drop_cnt   <= cnt_clr ? '0 : drop_cnt + CNT_W'(drop);
      end
   end

endmodule

// File: rtl/io_trig_filter.sv
// Two independent trigger channels sharing one register set; fan-out only.
module io_trig_filter
   import trig_pkg::*;
#(
   parameter int FILT_W = FILT_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FILT_W-1:0] reg_filter_len,
   input  logic [HOLD_W-1:0] reg_holdoff,
   input  logic [1:0]        reg_trig_en,
   input  logic              reg_cnt_clr,
   input  logic              pol_io_input_0,
   input  logic              pol_io_input_1,
   output logic              filt_level_0,
   output logic              filt_level_1,
   output logic              trig_pulse_0,
   output logic              trig_pulse_1,
   output logic [CNT_W-1:0]  trig_cnt_0,
   output logic [CNT_W-1:0]  trig_cnt_1,
   output logic [CNT_W-1:0]  drop_cnt_0,
   output logic [CNT_W-1:0]  drop_cnt_1
);

   logic [1:0]            din;
   logic [1:0]            lvl;
   logic [1:0]            pulse;
   logic [1:0][CNT_W-1:0] tcnt;
   logic [1:0][CNT_W-1:0] dcnt;

   assign din = {pol_io_input_1, pol_io_input_0};

   for (genvar i = 0; i < 2; i++) begin : g_chan
      io_trig_chan #(
         .FILT_W (FILT_W),
         .HOLD_W (HOLD_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .filter_len (reg_filter_len),
         .holdoff    (reg_holdoff),
         .trig_en    (reg_trig_en[i]),
         .cnt_clr    (reg_cnt_clr),
         .din        (din[i]),
         .filt_level (lvl[i]),
         .trig_pulse (pulse[i]),
         .trig_cnt   (tcnt[i]),
         .drop_cnt   (dcnt[i])
      );
   end

   assign filt_level_0 = lvl[0];
   assign filt_level_1 = lvl[1];
   assign trig_pulse_0 = pulse[0];
   assign trig_pulse_1 = pulse[1];
   assign trig_cnt_0   = tcnt[0];
   assign trig_cnt_1   = tcnt[1];
   assign drop_cnt_0   = dcnt[0];
   assign drop_cnt_1   = dcnt[1];

endmodule

// File: tb/tb_io_trig_filter.sv
// Bench for io_trig_filter: directed scenarios plus randomized traffic against a
// window/timestamp reference model.
module tb_io_trig_filter;
   import trig_pkg::*;

   localparam int FW = FILT_W_DEF;
   localparam int HW = HOLD_W_DEF;
   localparam int CW = CNT_W_DEF;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [FW-1:0] reg_filter_len = '0;
   logic [HW-1:0] reg_holdoff = '0;
   logic [1:0]    reg_trig_en = '0;
   logic          reg_cnt_clr = 1'b0;
   logic          pol_io_input_0 = 1'b0;
   logic          pol_io_input_1 = 1'b0;
   logic          filt_level_0, filt_level_1, trig_pulse_0, trig_pulse_1;
   logic [CW-1:0] trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1;

   always #5 clk = ~clk;

   io_trig_filter dut (
      .clk            (clk),
      .rst            (rst),
      .reg_filter_len (reg_filter_len),
      .reg_holdoff    (reg_holdoff),
      .reg_trig_en    (reg_trig_en),
      .reg_cnt_clr    (reg_cnt_clr),
      .pol_io_input_0 (pol_io_input_0),
      .pol_io_input_1 (pol_io_input_1),
      .filt_level_0   (filt_level_0),
      .filt_level_1   (filt_level_1),
      .trig_pulse_0   (trig_pulse_0),
      .trig_pulse_1   (trig_pulse_1),
      .trig_cnt_0     (trig_cnt_0),
      .trig_cnt_1     (trig_cnt_1),
      .drop_cnt_0     (drop_cnt_0),
      .drop_cnt_1     (drop_cnt_1)
   );

   int errors = 0;
   int checks = 0;
   int pc0 = 0;
   int pc1 = 0;

   // pulses seen during the cycle just ending
   always @(posedge clk) begin
      if (trig_pulse_0 === 1'b1) pc0++;
      if (trig_pulse_1 === 1'b1) pc1++;
   end

   // Reference model: the level flips when the last len+1 samples seen by the
   // filter all disagree with it; a rise is dropped if it lands within holdoff
   // cycles of the last accepted one.
   bit          m_hist [2][64];
   bit          m_f1 [2];
   bit          m_f2 [2];
   bit          m_has [2];
   int          m_last [2];
   int          m_t;
   bit          m_pulse [2];
   logic [CW-1:0] m_tc [2];
   logic [CW-1:0] m_dc [2];

   always @(posedge clk) begin
      bit in_c, rise, flip, acc, drp;
      if (!rst) begin
         m_t = 0;
         for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 64; k++) m_hist[c][k] = 1'b0;
            m_f1[c] = 0; m_f2[c] = 0; m_has[c] = 0; m_last[c] = 0;
            m_pulse[c] = 0; m_tc[c] = '0; m_dc[c] = '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            in_c = (c == 0) ? pol_io_input_0 : pol_io_input_1;
            rise = m_f1[c] && !m_f2[c];
            flip = 1'b1;
            for (int j = 0; j <= int'(reg_filter_len) && j < 62; j++)
               if (m_hist[c][1+j] == m_f1[c]) flip = 1'b0;
            acc = 1'b0;
            drp = 1'b0;
            if (rise && reg_trig_en[c]) begin
               if (m_has[c] && reg_holdoff != '0 && (m_t - m_last[c]) <= int'(reg_holdoff)) drp = 1'b1;
               else begin
                  acc = 1'b1; m_has[c] = 1'b1; m_last[c] = m_t;
               end
            end
            m_pulse[c] = acc;
            m_tc[c] = reg_cnt_clr ? '0 : m_tc[c] + CW'(acc);
            m_dc[c] = reg_cnt_clr ? '0 : m_dc[c] + CW'(drp);
            m_f2[c] = m_f1[c];
            if (flip) m_f1[c] = !m_f1[c];
            for (int k = 63; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = in_c;
         end
         m_t++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; reg_cnt_clr = 1'b0; pol_io_input_0 = 1'b0; pol_io_input_1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({filt_level_0, filt_level_1, trig_pulse_0, trig_pulse_1} !== 4'b0) begin
         errors++; $display("FAIL reset_bits got=%b want=0000", {filt_level_0, filt_level_1, trig_pulse_0, trig_pulse_1});
      end
      checks++;
      if ({trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1} !== '0) begin
         errors++; $display("FAIL reset_cnts got=%0d/%0d/%0d/%0d want=0", trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1);
      end
   endtask

   task automatic test_clean_edge();
      int p1;
      do_reset();
      reg_filter_len = 3; reg_holdoff = 0; reg_trig_en = 2'b11;
      tick(2);
      p1 = pc1;
      pol_io_input_0 = 1'b1;
      tick(5);
      checks++;
      if (filt_level_0 !== 1'b0) begin errors++; $display("FAIL clean_early got=%b want=0", filt_level_0); end
      tick(1);
      checks++;
      if (filt_level_0 !== 1'b1 || trig_pulse_0 !== 1'b0) begin
         errors++; $display("FAIL clean_level got=%b/%b want=1/0", filt_level_0, trig_pulse_0);
      end
      tick(1);
      checks++;
      if (trig_pulse_0 !== 1'b1 || trig_cnt_0 !== 1) begin
         errors++; $display("FAIL clean_pulse got=%b cnt=%0d want=1 cnt=1", trig_pulse_0, trig_cnt_0);
      end
      tick(1);
      checks++;
      if (trig_pulse_0 !== 1'b0) begin errors++; $display("FAIL clean_single got=%b want=0", trig_pulse_0); end
      tick(12);
      pol_io_input_0 = 1'b0;
      tick(10);
      checks++;
      if (trig_cnt_0 !== 1 || filt_level_0 !== 1'b0) begin
         errors++; $display("FAIL clean_after got cnt=%0d lvl=%b want cnt=1 lvl=0", trig_cnt_0, filt_level_0);
      end
      checks++;
      if (filt_level_1 !== 1'b0 || trig_cnt_1 !== 0 || drop_cnt_1 !== 0 || pc1 != p1) begin
         errors++; $display("FAIL clean_ch1 got lvl=%b cnt=%0d drop=%0d pulses=%0d want all 0", filt_level_1, trig_cnt_1, drop_cnt_1, pc1 - p1);
      end
   endtask

   task automatic test_glitch();
      int p1;
      bit seen;
      do_reset();
      reg_filter_len = 3; reg_holdoff = 0; reg_trig_en = 2'b11;
      tick(2);
      p1 = pc1; seen = 0;
      pol_io_input_1 = 1'b1; tick(3); pol_io_input_1 = 1'b0;
      repeat (12) begin tick(1); if (filt_level_1) seen = 1; end
      checks++;
      if (seen || pc1 != p1 || trig_cnt_1 !== 0 || drop_cnt_1 !== 0) begin
         errors++; $display("FAIL glitch_3 got seen=%b pulses=%0d cnt=%0d drop=%0d want 0", seen, pc1 - p1, trig_cnt_1, drop_cnt_1);
      end
      pol_io_input_1 = 1'b1; tick(4); pol_io_input_1 = 1'b0;
      repeat (14) begin tick(1); if (filt_level_1) seen = 1; end
      checks++;
      if (!seen || pc1 - p1 != 1 || trig_cnt_1 !== 1) begin
         errors++; $display("FAIL glitch_4 got seen=%b pulses=%0d cnt=%0d want 1/1/1", seen, pc1 - p1, trig_cnt_1);
      end
   endtask

   task automatic test_holdoff();
      do_reset();
      reg_filter_len = 0; reg_holdoff = 10; reg_trig_en = 2'b01;
      tick(2);
      // rises 5 apart
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(3);
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(20);
      checks++;
      if (trig_cnt_0 !== 1 || drop_cnt_0 !== 1) begin
         errors++; $display("FAIL hold_5 got trig=%0d drop=%0d want 1/1", trig_cnt_0, drop_cnt_0);
      end
      // rises 11 apart
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(9);
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(20);
      checks++;
      if (trig_cnt_0 !== 3 || drop_cnt_0 !== 1) begin
         errors++; $display("FAIL hold_11 got trig=%0d drop=%0d want 3/1", trig_cnt_0, drop_cnt_0);
      end
      // rise in the exit cycle is dropped, a later one is accepted
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(8);
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(1);
      pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(20);
      checks++;
      if (trig_cnt_0 !== 5 || drop_cnt_0 !== 2) begin
         errors++; $display("FAIL hold_exit got trig=%0d drop=%0d want 5/2", trig_cnt_0, drop_cnt_0);
      end
   endtask

   task automatic test_disable();
      int p0, p1;
      do_reset();
      reg_filter_len = 1; reg_holdoff = 0; reg_trig_en = 2'b00;
      tick(2);
      p0 = pc0; p1 = pc1;
      repeat (4) begin
         pol_io_input_0 = 1; pol_io_input_1 = 1; tick(4);
         checks++;
         if (filt_level_0 !== 1'b1 || filt_level_1 !== 1'b1) begin
            errors++; $display("FAIL dis_high got=%b%b want=11", filt_level_1, filt_level_0);
         end
         tick(2);
         pol_io_input_0 = 0; pol_io_input_1 = 0; tick(4);
         checks++;
         if (filt_level_0 !== 1'b0 || filt_level_1 !== 1'b0) begin
            errors++; $display("FAIL dis_low got=%b%b want=00", filt_level_1, filt_level_0);
         end
         tick(2);
      end
      checks++;
      if (pc0 != p0 || pc1 != p1 || {trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1} !== '0) begin
         errors++; $display("FAIL dis_cnt got pulses=%0d/%0d cnts=%0d/%0d/%0d/%0d want 0", pc0 - p0, pc1 - p1, trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1);
      end
   endtask

   task automatic test_clear_collision();
      do_reset();
      reg_filter_len = 0; reg_holdoff = 0; reg_trig_en = 2'b01;
      tick(2);
      repeat (7) begin pol_io_input_0 = 1; tick(2); pol_io_input_0 = 0; tick(3); end
      tick(4);
      checks++;
      if (trig_cnt_0 !== 7) begin errors++; $display("FAIL clr_pre got=%0d want=7", trig_cnt_0); end
      pol_io_input_0 = 1; tick(3);
      reg_cnt_clr = 1; tick(1); reg_cnt_clr = 0;
      checks++;
      if (trig_pulse_0 !== 1'b1 || trig_cnt_0 !== 0) begin
         errors++; $display("FAIL clr_collide got pulse=%b cnt=%0d want 1/0", trig_pulse_0, trig_cnt_0);
      end
      pol_io_input_0 = 0; tick(6);
      checks++;
      if (trig_cnt_0 !== 0) begin errors++; $display("FAIL clr_after got=%0d want=0", trig_cnt_0); end
   endtask

   task automatic test_reset_mid_hold();
      int cyc;
      do_reset();
      reg_filter_len = 2; reg_holdoff = 1000; reg_trig_en = 2'b01;
      tick(2);
      pol_io_input_0 = 1; cyc = 0;
      for (int i = 1; i <= 20 && cyc == 0; i++) begin tick(1); if (trig_pulse_0) cyc = i; end
      checks++;
      if (cyc != 6 || trig_cnt_0 !== 1) begin
         errors++; $display("FAIL rh_first got lat=%0d cnt=%0d want 6/1", cyc, trig_cnt_0);
      end
      tick(50);
      rst = 0; tick(1); rst = 1;
      checks++;
      if ({filt_level_0, filt_level_1, trig_pulse_0, trig_pulse_1} !== 4'b0 ||
          {trig_cnt_0, trig_cnt_1, drop_cnt_0, drop_cnt_1} !== '0) begin
         errors++; $display("FAIL rh_reset got lvl=%b pulse=%b cnt=%0d drop=%0d want 0", filt_level_0, trig_pulse_0, trig_cnt_0, drop_cnt_0);
      end
      cyc = 0;
      for (int i = 1; i <= 20 && cyc == 0; i++) begin tick(1); if (trig_pulse_0) cyc = i; end
      checks++;
      if (cyc != 6 || trig_cnt_0 !== 1 || drop_cnt_0 !== 0) begin
         errors++; $display("FAIL rh_after got lat=%0d cnt=%0d drop=%0d want 6/1/0", cyc, trig_cnt_0, drop_cnt_0);
      end
      pol_io_input_0 = 0;
   endtask

   task automatic test_random();
      int run [2];
      bit lvl [2];
      for (int cfg = 0; cfg < 6; cfg++) begin
         do_reset();
         reg_filter_len = FW'($urandom_range(0, 4));
         reg_holdoff    = HW'($urandom_range(0, 12));
         reg_trig_en    = 2'($urandom_range(0, 3));
         run[0] = 0; run[1] = 0; lvl[0] = 0; lvl[1] = 0;
         repeat (400) begin
            for (int c = 0; c < 2; c++) begin
               checks++;
               if ((c == 0 ? filt_level_0 : filt_level_1) !== m_f1[c] ||
                   (c == 0 ? trig_pulse_0 : trig_pulse_1) !== m_pulse[c] ||
                   (c == 0 ? trig_cnt_0 : trig_cnt_1) !== m_tc[c] ||
                   (c == 0 ? drop_cnt_0 : drop_cnt_1) !== m_dc[c]) begin
                  errors++;
                  if (errors < 20)
                     $display("FAIL rand_ch%0d cfg=%0d got lvl=%b p=%b tc=%0d dc=%0d want lvl=%b p=%b tc=%0d dc=%0d", c, cfg,
                        (c == 0 ? filt_level_0 : filt_level_1), (c == 0 ? trig_pulse_0 : trig_pulse_1),
                        (c == 0 ? trig_cnt_0 : trig_cnt_1), (c == 0 ? drop_cnt_0 : drop_cnt_1),
                        m_f1[c], m_pulse[c], m_tc[c], m_dc[c]);
               end
               if (run[c] == 0) begin
                  lvl[c] = !lvl[c];
                  run[c] = $urandom_range(1, 8);
               end
               run[c]--;
            end
            pol_io_input_0 = lvl[0];
            pol_io_input_1 = lvl[1];
            reg_cnt_clr = ($urandom_range(0, 39) == 0);
            tick(1);
         end
         reg_cnt_clr = 0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_edge();
      test_glitch();
      test_holdoff();
      test_disable();
      test_clear_collision();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_trig_filter.md
# io_trig_filter

Conditions the two polarity-normalised trigger inputs in the trigger-control path. Each channel is synchronised, glitch-filtered with a programmable stability window, and rising-edge detected. A holdoff state machine then limits the trigger rate, and each channel keeps accepted and dropped trigger counts. The block sits directly downstream of the polarity stage and feeds single-cycle trigger pulses to the trigger sequencer.

## Interface
- FILT_W, 16: width of the filter-length register and the stability counter
- HOLD_W, 24: width of the holdoff register and the holdoff counter
- CNT_W, 32: width of the trigger and drop counters
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous and active-low
- reg_filter_len  in  FILT_W  stability window; the input must disagree with the filtered level for reg_filter_len+1 consecutive cycles to flip it
- reg_holdoff  in  HOLD_W  number of cycles after an accepted trigger during which new rising edges are rejected
- reg_trig_en  in  2  per-channel enable; bit i controls channel i
- reg_cnt_clr  in  1  synchronous clear of all counters, level-sensitive
- pol_io_input_0  in  1  polarity-normalised input, channel 0, asynchronous to clk
- pol_io_input_1  in  1  polarity-normalised input, channel 1, asynchronous to clk
- filt_level_0  out  1  filtered level, channel 0
- filt_level_1  out  1  filtered level, channel 1
- trig_pulse_0  out  1  one-cycle accepted trigger, channel 0
- trig_pulse_1  out  1  one-cycle accepted trigger, channel 1
- trig_cnt_0  out  CNT_W  accepted-trigger count, channel 0
- trig_cnt_1  out  CNT_W  accepted-trigger count, channel 1
- drop_cnt_0  out  CNT_W  count of rising edges rejected by holdoff, channel 0
- drop_cnt_1  out  CNT_W  count of rising edges rejected by holdoff, channel 1

## Operation
The two channels are identical and fully independent. The register inputs are shared and treated as quasi-static.

- **Sync:** two-flop synchroniser `s`, reset value 0.
- **Filter:** `stab_cnt` and `filt_level`.
  - If `s == filt_level`: `stab_cnt <= 0`.
  - Else if `stab_cnt == reg_filter_len`: `filt_level <= s` and `stab_cnt <= 0`.
  - Else: `stab_cnt <= stab_cnt + 1`.
  - With reg_filter_len = 0, the level follows `s` with one register stage.
  - A glitch shorter than reg_filter_len+1 cycles never reaches filt_level.
- **Edge:** `rise = filt_level & ~filt_level_d`. Falling edges are not used.
- **FSM:** two states, IDLE and HOLD.
  - IDLE, `rise & reg_trig_en[i]`: assert trig_pulse next cycle; trig_cnt +1.
    - If reg_holdoff == 0, stay in IDLE.
    - Else `hold_cnt <= reg_holdoff`, go to HOLD.
  - HOLD: `hold_cnt` decrements each cycle; when `hold_cnt == 1`, go to IDLE.
  - HOLD, `rise & reg_trig_en[i]`: no pulse; drop_cnt +1.
  - `rise & ~reg_trig_en[i]`, any state: ignored, no counter change. The HOLD countdown continues regardless of the enable.
- **Counters:**
  - Wrap from all-ones to 0.
  - reg_cnt_clr has priority over an increment in the same cycle, so the counter reads 0 after that cycle.
  - reg_cnt_clr does not affect the FSM or the filter.
- **Register changes mid-operation:**
  - Changing reg_holdoff during HOLD does not affect the running count.
  - Changing reg_filter_len takes effect on the next compare.

## Timing
- All outputs are registered. Every output resets to 0, as do all internal state, and the FSM resets to IDLE.
- Reset is honoured on the clock edge where `rst == 0`, including mid-HOLD or mid-filter. The block is in its reset state the cycle after.
- Latency for a clean step sampled at edge k:
  - `s` is high after edge k+2.
  - filt_level is high after edge k+2+reg_filter_len+1.
  - trig_pulse is high for the single cycle after the edge that follows filt_level going high.
  - trig_cnt updates in the same cycle as trig_pulse.
- Minimum spacing between accepted pulses is reg_holdoff+1 cycles when reg_holdoff > 0, and is otherwise limited only by the filter.
- An edge arriving in the cycle HOLD exits (`hold_cnt == 1`) is dropped. An edge one cycle later is accepted.

## Structure
- Package `trig_pkg`:
  - enum `trig_fsm_t` with values IDLE and HOLD
  - default constants for FILT_W, HOLD_W and CNT_W, shared with the register block
- Sub-module `io_trig_chan`: one channel (sync, filter, edge, FSM, counters), parameterised identically.
- The top level instantiates `io_trig_chan` twice and does the port fan-out only.

## Test plan
- **Clean edge:** len=3, holdoff=0, en=2'b11; ch0 input high for 20 cycles from edge k -> filt_level_0 high after edge k+6; trig_pulse_0 high for exactly one cycle; trig_cnt_0=1; channel 1 unchanged.
- **Glitch rejection:** len=3; ch1 input high for 3 cycles, then low -> filt_level_1 stays 0; no pulse; both counters 0. A 4-cycle high flips the level and gives one pulse.
- **Holdoff:** holdoff=10, len=0; filtered rises 5 cycles apart -> one pulse, trig_cnt_0=1, drop_cnt_0=1. Rises 11 cycles apart -> two pulses, drop_cnt_0 unchanged.
- **Disable:** en=2'b00; 4 clean edges on each channel -> no pulses; all counters stay 0; filt_levels still track the inputs.
- **Clear collision:** reg_cnt_clr asserted in the same cycle as an accepted pulse with trig_cnt_0=7 -> pulse still emitted; trig_cnt_0=0 the next cycle.
- **Reset mid-HOLD:** holdoff=1000; pulse, then rst=0 for 1 cycle 50 cycles later -> all outputs 0 next cycle; FSM in IDLE. A new edge after reset is accepted after the 2+len+1+1 cycle latency.
